// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS pipeline.
// Variable-latency ready/valid fetch, bubble insertion and delayed-branch redirect.
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        nostall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] dpc4,
  output logic [31:0] dinst
);

  typedef enum logic [0:0] {
    ST_REQ = 1'b0,
    ST_BUF = 1'b1
  } st_t;

  st_t         st_r;
  logic [31:0] pc_r;
  logic [31:0] ibuf_r;
  logic        redir_v_r;
  logic [31:0] redir_pc_r;

  logic        avail_s;
  logic [31:0] inst_s;
  logic        take_s;
  logic [31:0] tgt_s;
  logic [31:0] pc4_s;

  // Memory-facing outputs depend on state only, never on imem_ready/imem_rdata.
  assign imem_req  = (st_r == ST_REQ);
  assign imem_addr = pc_r;
  assign pc4_s     = pc_r + 32'd4;
  assign take_s    = nostall & (pcsource != 2'b00);

  // Instruction source: buffered word while parked, otherwise the live response.
  always_comb begin
    avail_s = 1'b0;
    inst_s  = imem_rdata;
    if (st_r == ST_BUF) begin
      avail_s = 1'b1;
      inst_s  = ibuf_r;
    end else begin
      avail_s = imem_ready;
      inst_s  = imem_rdata;
    end
  end

  // Control-transfer target selected by decode.
  always_comb begin
    tgt_s = pc4_s;
    case (pcsource)
      2'b01:   tgt_s = bpc;
      2'b10:   tgt_s = da;
      2'b11:   tgt_s = jpc;
      default: tgt_s = pc4_s;
    endcase
  end

  // PC, fetch state, redirect latch and IF/ID register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_r       <= RESET_PC;
      st_r       <= ST_REQ;
      ibuf_r     <= 32'h0000_0000;
      redir_v_r  <= 1'b0;
      redir_pc_r <= 32'h0000_0000;
      dpc4       <= 32'h0000_0000;
      dinst      <= 32'h0000_0000;
    end else if (nostall) begin
      dpc4 <= pc4_s;
      if (avail_s) begin
        // Delivered word is the delay slot; a pending redirect takes effect now.
        dinst     <= inst_s;
        pc_r      <= take_s ? tgt_s : (redir_v_r ? redir_pc_r : pc4_s);
        redir_v_r <= 1'b0;
        st_r      <= ST_REQ;
      end else begin
        dinst <= 32'h0000_0000;
        if (take_s) begin
          redir_v_r  <= 1'b1;
          redir_pc_r <= tgt_s;
        end
      end
    end else if ((st_r == ST_REQ) && imem_ready) begin
      ibuf_r <= imem_rdata;
      st_r   <= ST_BUF;
    end
  end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed table-driven bench for pipeif_fetch; memory returns word = address.
`timescale 1ns/1ps
module tb_pipeif_fetch;

  logic        clk;
  logic        clr;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] da;
  logic        nostall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] dpc4;
  logic [31:0] dinst;
  logic        stale;

  int checks;
  int errors;

  pipeif_fetch dut (
    .clk        (clk),
    .clr        (clr),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .da         (da),
    .nostall    (nostall),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .dpc4       (dpc4),
    .dinst      (dinst)
  );

  // A stale response models memory answering the pre-reset address.
  assign imem_rdata = stale ? 32'h0000_0020 : imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: optional reset pulse, inputs for the coming edge, outputs expected before it.
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ns;
    logic [1:0]  ps;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic rst, input logic rdy, input logic ns, input logic [1:0] ps,
                            input logic req, input logic [31:0] addr, input logic [31:0] pc4,
                            input logic [31:0] inst);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.ns = ns; r.ps = ps;
    r.req = req; r.addr = addr; r.pc4 = pc4; r.inst = inst;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int row, input logic req, input logic [31:0] addr,
                         input logic [31:0] pc4, input logic [31:0] inst);
    chk({tag, ".imem_req"}, row, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"}, row, imem_addr, addr);
    chk({tag, ".dpc4"}, row, dpc4, pc4);
    chk({tag, ".dinst"}, row, dinst, inst);
  endtask

  initial begin
    checks = 0; errors = 0;
    clr = 1'b1; stale = 1'b0;
    pcsource = 2'b00; nostall = 1'b1; imem_ready = 1'b1;
    bpc = 32'h0000_0040; da = 32'h0000_0100; jpc = 32'hFFFF_FFFC;

    // Zero-wait streaming.
    v(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hC, 32'hC, 32'h8);
    // Ready low two of every three cycles.
    v(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h4, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h4, 32'h8, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h8, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h8, 32'hC, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h8, 32'hC, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hC, 32'hC, 32'h8);
    // Word for 0x8 returns during a 3-cycle stall; pcsource ignored while stalled.
    v(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hC, 32'hC, 32'h8);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h10, 32'h10, 32'hC);
    // Branch at 0x8 to 0x40 with zero-wait delay slot.
    v(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hC, 32'hC, 32'h8);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h40, 32'h10, 32'hC);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h44, 32'h44, 32'h40);
    // jr at 0x8 to 0x100 while the delay-slot fetch waits three cycles.
    v(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h8, 32'h8, 32'h4);
    v(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'hC, 32'hC, 32'h8);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hC, 32'h10, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hC, 32'h10, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hC, 32'h10, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h100, 32'h10, 32'hC);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h104, 32'h104, 32'h100);
    // Jump to 0xFFFF_FFFC, then PC+4 wraps to zero.
    v(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 32'h4, 32'h4, 32'h0);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h4);
    v(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC);

    #12 clr = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        clr = 1'b1;
        #1 clr = 1'b0;
      end
      imem_ready = tbl[i].rdy;
      nostall    = tbl[i].ns;
      pcsource   = tbl[i].ps;
      #1;
      chk_all("vec", i, tbl[i].req, tbl[i].addr, tbl[i].pc4, tbl[i].inst);
    end

    // Asynchronous clear in the middle of a wait at pc=0x20.
    @(negedge clk);
    clr = 1'b1;
    #1 clr = 1'b0;
    imem_ready = 1'b1; nostall = 1'b1; pcsource = 2'b00;
    repeat (8) @(negedge clk);
    imem_ready = 1'b0; nostall = 1'b0;
    @(negedge clk);
    chk_all("clr_pre", 0, 1'b1, 32'h20, 32'h20, 32'h1C);
    #2 clr = 1'b1;
    #1;
    chk_all("clr_async", 1, 1'b1, 32'h0, 32'h0, 32'h0);
    stale = 1'b1; imem_ready = 1'b1; nostall = 1'b1;
    @(negedge clk);
    chk_all("clr_held", 2, 1'b1, 32'h0, 32'h0, 32'h0);
    clr = 1'b0; stale = 1'b0;
    @(negedge clk);
    chk_all("clr_after", 3, 1'b1, 32'h4, 32'h4, 32'h0);
    @(negedge clk);
    chk_all("clr_next", 4, 1'b1, 32'h8, 32'h8, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
